// File: rtl/rtc_bus_scheduler.sv
// Sequences RTC bus cycles: arbitrates edit-controller writes against periodic or
// forced read bursts, drives one start/done cycle at a time and aborts hung cycles.
module rtc_bus_scheduler #(
    parameter int unsigned REFRESH_CYCLES = 100000,
    parameter logic [7:0]  RD_BASE_ADDR   = 8'h21,
    parameter int unsigned RD_COUNT       = 6,
    parameter int unsigned TIMEOUT        = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_req,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_ack,
    input  logic       rd_force,
    output logic       bus_start,
    output logic       bus_rw,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    input  logic       bus_done,
    input  logic [7:0] bus_rdata,
    output logic       rd_valid,
    output logic [2:0] rd_index,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       err,
    output logic [1:0] estado
);

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] START = 2'b01;
    localparam logic [1:0] WAIT  = 2'b10;
    localparam logic [1:0] NEXT  = 2'b11;

    localparam int unsigned CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [2:0]    IDX_LAST = 3'(RD_COUNT - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          pending_q, pending_d;
    logic          burst_q, burst_d;
    logic [2:0]    idx_q, idx_d;
    logic          rw_q, rw_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          wr_ack_q, wr_ack_d;
    logic          rd_valid_q, rd_valid_d;
    logic [2:0]    rd_index_q, rd_index_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          err_q, err_d;
    logic          refresh_tc;

    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        pending_d  = pending_q;
        burst_d    = burst_q;
        idx_d      = idx_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_index_d = rd_index_q;
        rd_data_d  = rd_data_q;
        wr_ack_d   = 1'b0;
        rd_valid_d = 1'b0;
        err_d      = 1'b0;

        refresh_tc = (cnt_q == CNT_LAST);
        cnt_d      = refresh_tc ? '0 : cnt_q + 1'b1;

        // Refresh requests arriving while a burst runs are dropped, not queued.
        if (!burst_q && (refresh_tc || rd_force)) begin
            pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (wr_req) begin
                    addr_d  = wr_addr;
                    wdata_d = wr_data;
                    rw_d    = 1'b0;
                    state_d = START;
                end else if (pending_q) begin
                    pending_d = 1'b0;
                    burst_d   = 1'b1;
                    idx_d     = 3'd0;
                    addr_d    = RD_BASE_ADDR;
                    rw_d      = 1'b1;
                    state_d   = START;
                end
            end
            START: begin
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus_done) begin
                    if (rw_q) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = bus_rdata;
                        rd_index_d = idx_q;
                    end else begin
                        wr_ack_d = 1'b1;
                    end
                    state_d = NEXT;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    burst_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            NEXT: begin
                // A completed read (rw_q=1) lets a waiting write cut in; a completed
                // write never re-issues itself while its requester drops wr_req.
                if (wr_req && rw_q) begin
                    addr_d  = wr_addr;
                    wdata_d = wr_data;
                    rw_d    = 1'b0;
                    state_d = START;
                end else if (burst_q && (idx_q < IDX_LAST)) begin
                    idx_d   = idx_q + 3'd1;
                    addr_d  = RD_BASE_ADDR + {5'd0, idx_q + 3'd1};
                    rw_d    = 1'b1;
                    state_d = START;
                end else begin
                    burst_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            tmo_q      <= '0;
            pending_q  <= 1'b0;
            burst_q    <= 1'b0;
            idx_q      <= 3'd0;
            rw_q       <= 1'b0;
            addr_q     <= 8'd0;
            wdata_q    <= 8'd0;
            wr_ack_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_index_q <= 3'd0;
            rd_data_q  <= 8'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            pending_q  <= pending_d;
            burst_q    <= burst_d;
            idx_q      <= idx_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wr_ack_q   <= wr_ack_d;
            rd_valid_q <= rd_valid_d;
            rd_index_q <= rd_index_d;
            rd_data_q  <= rd_data_d;
            err_q      <= err_d;
        end
    end

    assign bus_start = (state_q == START);
    assign bus_rw    = rw_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign wr_ack    = wr_ack_q;
    assign rd_valid  = rd_valid_q;
    assign rd_index  = rd_index_q;
    assign rd_data   = rd_data_q;
    assign err       = err_q;
    assign busy      = (state_q != IDLE);
    assign estado    = state_q;

endmodule
